// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared constants, widths and state encoding for the UART boot loader
package boot_pkg;

    localparam logic [7:0] BOOT_MAGIC = 8'hB0;
    localparam int         LEN_W      = 16;
    localparam int         BIDX_W     = 2;

`ifdef BOOT_CHKSUM_EN
    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_LO     = 3'd1,
        ST_LEN_HI     = 3'd2,
        ST_DATA       = 3'd3,
        ST_CHK        = 3'd4,
        ST_RUN        = 3'd5,
        ST_ERR        = 3'd6
    } boot_state_e;
`else
    typedef enum logic [2:0] {
        ST_WAIT_MAGIC = 3'd0,
        ST_LEN_LO     = 3'd1,
        ST_LEN_HI     = 3'd2,
        ST_DATA       = 3'd3,
        ST_RUN        = 3'd5,
        ST_ERR        = 3'd6
    } boot_state_e;
`endif

    // Bits needed for a counter that must reach timeout-1.
    function automatic int to_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// rtl/boot_word_asm.sv - packs four little-endian bytes into a word and pulses word_valid
module boot_word_asm
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        flush,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [23:0]       sh_q, sh_d;
    logic [31:0]       word_q, word_d;
    logic              valid_q, valid_d;

    always_comb begin
        bidx_d  = bidx_q;
        sh_d    = sh_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (flush) begin
            bidx_d = '0;
            sh_d   = '0;
        end else if (byte_valid) begin
            // Earlier bytes shift down so the first one ends up in bits 7:0.
            if (bidx_q == BIDX_W'(3)) begin
                word_d  = {byte_data, sh_q};
                valid_d = 1'b1;
                bidx_d  = '0;
            end else begin
                sh_d   = {byte_data, sh_q[23:8]};
                bidx_d = bidx_q + BIDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bidx_q  <= '0;
            sh_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word_data  = word_q;

endmodule

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - loads a length-prefixed program from UART bytes into IMEM, then releases the core
// Optional trailing XOR checksum byte enabled by macro BOOT_CHKSUM_EN.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_DEPTH   = 256,
    parameter int BYTE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_clr,
    output logic        boot_done,
    output logic        err
);

    localparam int              TO_W    = to_width(BYTE_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BYTE_TIMEOUT - 1);

    boot_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] widx_q, widx_d;
    logic [TO_W-1:0]  to_q, to_d;
`ifdef BOOT_CHKSUM_EN
    logic [7:0]       xor_q, xor_d;
`endif

    logic             word_valid;
    logic [31:0]      word_data;
    logic             timing;
    logic             expired;
    logic [LEN_W-1:0] new_len;

    boot_word_asm u_word_asm (
        .clk        (clk),
        .clr        (clr),
        .flush      (state_q != ST_DATA),
        .byte_valid (rx_ready && (state_q == ST_DATA)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    assign new_len = {rx_data, len_q[7:0]};

`ifdef BOOT_CHKSUM_EN
    assign timing = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA)   || (state_q == ST_CHK);
`else
    assign timing = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                    (state_q == ST_DATA);
`endif

    // A byte landing in the expiry cycle wins over the timeout.
    assign expired = timing && !rx_ready && (to_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        to_d    = '0;
`ifdef BOOT_CHKSUM_EN
        xor_d   = xor_q;
`endif
        if (timing && !rx_ready) begin
            to_d = to_q + TO_W'(1);
        end

        case (state_q)
            ST_WAIT_MAGIC: begin
                if (rx_ready && rx_data == BOOT_MAGIC) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (rx_ready) begin
                    len_d   = {{(LEN_W-8){1'b0}}, rx_data};
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_ready) begin
                    len_d  = new_len;
                    widx_d = '0;
`ifdef BOOT_CHKSUM_EN
                    xor_d  = '0;
`endif
                    if (new_len == '0 || int'(new_len) > IMEM_DEPTH) state_d = ST_ERR;
                    else                                             state_d = ST_DATA;
                end
            end
            ST_DATA: begin
`ifdef BOOT_CHKSUM_EN
                if (rx_ready) xor_d = xor_q ^ rx_data;
`endif
                if (word_valid) begin
                    widx_d = widx_q + LEN_W'(1);
                    if (widx_q == len_q - LEN_W'(1)) begin
`ifdef BOOT_CHKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_RUN;
`endif
                    end
                end
            end
`ifdef BOOT_CHKSUM_EN
            ST_CHK: begin
                if (rx_ready) state_d = (rx_data == xor_q) ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_ERR: begin
                if (rx_ready && rx_data == BOOT_MAGIC) state_d = ST_LEN_LO;
            end
            default: state_d = ST_WAIT_MAGIC;
        endcase

        if (expired) state_d = ST_ERR;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_WAIT_MAGIC;
            len_q   <= '0;
            widx_q  <= '0;
            to_q    <= '0;
`ifdef BOOT_CHKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            to_q    <= to_d;
`ifdef BOOT_CHKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign imem_we    = word_valid;
    assign imem_waddr = 32'(widx_q);
    assign imem_wdata = word_data;
    assign cpu_clr    = (state_q != ST_RUN);
    assign boot_done  = (state_q == ST_RUN);
    assign err        = (state_q == ST_ERR);

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, giving the instruction-memory size in 32-bit words.
REQ-002 SHALL have parameter BYTE_TIMEOUT, default 1000000, giving the maximum clk cycles allowed between bytes while a load is in progress.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 8 bits: the received UART byte.
REQ-006 SHALL have port rx_ready, input, 1 bit: a one-cycle pulse marking rx_data valid.
REQ-007 SHALL have port imem_we, output, 1 bit: the instruction-memory write strobe.
REQ-008 SHALL have port imem_waddr, output, 32 bits: the word address, matching the +1-per-instruction PC.
REQ-009 SHALL have port imem_wdata, output, 32 bits: the instruction word to write.
REQ-010 SHALL have port cpu_clr, output, 1 bit: holds the core's PC and register file in reset while high.
REQ-011 SHALL have port boot_done, output, 1 bit: high once the core has been released.
REQ-012 SHALL have port err, output, 1 bit: high while the loader is in ERR.

Function
REQ-013 SHALL implement FSM states WAIT_MAGIC, LEN_LO, LEN_HI, DATA, CHK, RUN and ERR.
REQ-014 In WAIT_MAGIC, SHALL ignore every byte except 8'hB0, which moves the FSM to LEN_LO.
REQ-015 LEN_LO then LEN_HI SHALL capture the 16-bit word count N, little-endian.
REQ-016 If N==0 or N>IMEM_DEPTH, SHALL enter ERR on the LEN_HI byte; otherwise it SHALL enter DATA.
REQ-017 DATA SHALL assemble each group of 4 bytes little-endian (first byte -> bits 7:0) into one word.
REQ-018 SHALL assert imem_we for exactly 1 cycle, in the cycle after the rx_ready of each word's 4th byte, with imem_waddr = word index (0..N-1) and imem_wdata = the assembled word.
REQ-019 After word N-1 is written, SHALL go to CHK if BOOT_CHKSUM_EN is defined, else to RUN.
REQ-020 In RUN, SHALL drive cpu_clr=0 and boot_done=1, starting the cycle after the final imem_we pulse (or after checksum acceptance), and SHALL ignore all rx bytes until clr.
REQ-021 SHALL run a timeout counter in LEN_LO, LEN_HI, DATA and CHK only, cleared on every rx_ready; when it reaches BYTE_TIMEOUT-1, the FSM SHALL enter ERR and discard any partial word.
REQ-022 In ERR, SHALL hold cpu_clr=1 and err=1; a byte 8'hB0 SHALL clear err and restart at LEN_LO.
REQ-023 Words already written SHALL remain in memory after ERR and SHALL NOT be erased.
REQ-024 cpu_clr SHALL be 1 in every state except RUN.
REQ-025 The count, byte index and word index SHALL be wide enough for IMEM_DEPTH; the word index SHALL NOT wrap, given the REQ-016 bound.
REQ-026 An rx_ready arriving in the same cycle as the timeout expiry SHALL take priority: the byte is accepted and the counter is cleared.

Reset
REQ-027 While clr is high, SHALL asynchronously force: state=WAIT_MAGIC, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_clr=1, boot_done=0, err=0, all counters=0.
REQ-028 clr asserted mid-load SHALL abort the load; the next load SHALL restart from word 0.

Configuration
REQ-029 With macro BOOT_CHKSUM_EN defined, SHALL keep a running XOR over all DATA bytes and treat the byte received in CHK as the checksum.
REQ-030 With BOOT_CHKSUM_EN defined, a checksum match SHALL enter RUN and a mismatch SHALL enter ERR.
REQ-031 With BOOT_CHKSUM_EN undefined, SHALL omit the CHK state and the XOR register entirely.

Structure
REQ-032 Package boot_pkg SHALL hold the FSM state enum, the constant BOOT_MAGIC=8'hB0, and the widths of the length and counters.
REQ-033 Sub-module boot_word_asm SHALL hold the 4-byte shift/assemble logic and the byte index, and SHALL emit a one-cycle word_valid.
REQ-034 The FSM, timeout counter, word index and checksum SHALL live in uart_boot_loader.

Verification
REQ-035 Bytes B0 02 00 13 00 10 00 33 81 20 00 -> imem_we at addr 0 with data 00100013, then at addr 1 with data 00208133; cpu_clr falls the next cycle; boot_done=1.
REQ-036 Bytes 55 B0 01 00 AA BB CC DD -> 55 is ignored; a single write at addr 0 with data DDCCBBAA.
REQ-037 Bytes B0 00 00 -> err=1, cpu_clr=1, no imem_we; a following B0 01 00 plus 4 bytes -> recovery and RUN.
REQ-038 With BYTE_TIMEOUT=100, bytes B0 01 00 11, then 100 idle cycles -> ERR, no write; byte counter reset observed on the next load.
REQ-039 With BOOT_CHKSUM_EN, B0 01 00 01 02 04 08 0F -> RUN; the same stream ending in 0E -> err=1 with the word still written at addr 0.
REQ-040 clr pulsed after the 2nd data byte, then a full one-word load -> write at addr 0 with the correct little-endian word.
